// File: rtl/interboard_tx_sched_pkg.sv
// -----------------------------------------------------------------------------
// interboard_tx_sched_pkg
// Shared definitions for the inter-board transmit scheduler: message-type
// encodings, transmit FSM state encoding, message packing and the default
// link-completion timeout.
// Ports: none (package).
// -----------------------------------------------------------------------------
package interboard_tx_sched_pkg;

   // Cycles to wait for link completion before declaring a link error.
   localparam int TIMEOUT_DEFAULT = 1000;

   // Width of one queued message: {msg_type[2:0], number[4:0]}.
   localparam int MSG_WIDTH = 8;

   typedef enum logic [2:0] {
      MT_NOP      = 3'd0,
      MT_MOVE     = 3'd1,
      MT_ATTACK   = 3'd2,
      MT_SCORE    = 3'd3,
      MT_TURN_END = 3'd4,
      MT_STATUS   = 3'd5,
      MT_SYNC     = 3'd6,
      MT_RESET    = 3'd7
   } msg_type_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_LOW  = 2'd2,
      ST_WAIT_HIGH = 2'd3
   } tx_state_e;

   typedef struct packed {
      logic [2:0] msg_type;
      logic [4:0] number;
   } msg_t;

   // Pack requester fields into the FIFO word layout.
   function automatic msg_t pack_msg(input logic [2:0] msg_type, input logic [4:0] number);
      msg_t m;
      m.msg_type = msg_type;
      m.number   = number;
      return m;
   endfunction

endpackage

// File: rtl/interboard_tx_sched_if.sv
// -----------------------------------------------------------------------------
// interboard_tx_sched_if
// Handshake/bus bundle of the inter-board transmit scheduler.
//   master : requester/link side (drives valids, fields, transmit, inter_ready)
//   slave  : scheduler side (drives readys, ctrl_*, busy, fifo_count, link_err)
// Parameter DEPTH must match the scheduler's DEPTH (sizes fifo_count).
// -----------------------------------------------------------------------------
interface interboard_tx_sched_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          transmit;
   logic          inter_ready;
   logic          gc_valid;
   logic [4:0]    gc_number;
   logic [2:0]    gc_msg_type;
   logic          gc_ready;
   logic          ui_valid;
   logic [4:0]    ui_number;
   logic [2:0]    ui_msg_type;
   logic          ui_ready;
   logic          ctrl_en;
   logic [4:0]    ctrl_number;
   logic [2:0]    ctrl_msg_type;
   logic          busy;
   logic [CW-1:0] fifo_count;
   logic          link_err;

   modport master (
      output transmit, inter_ready,
      output gc_valid, gc_number, gc_msg_type,
      output ui_valid, ui_number, ui_msg_type,
      input  gc_ready, ui_ready,
      input  ctrl_en, ctrl_number, ctrl_msg_type,
      input  busy, fifo_count, link_err
   );

   modport slave (
      input  transmit, inter_ready,
      input  gc_valid, gc_number, gc_msg_type,
      input  ui_valid, ui_number, ui_msg_type,
      output gc_ready, ui_ready,
      output ctrl_en, ctrl_number, ctrl_msg_type,
      output busy, fifo_count, link_err
   );
endinterface

// File: rtl/interboard_tx_sched_msg_fifo.sv
// -----------------------------------------------------------------------------
// msg_fifo
// Synchronous FIFO with wrap-around pointers. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; a pop from an empty
// FIFO is ignored. rdata always shows the head entry.
// Ports:
//   clk, rst        clock, synchronous active-high flush
//   push, wdata     write request and data
//   pop             read request (head advances)
//   rdata           head entry
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module msg_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == CW'(0));
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);
   assign rdata     = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= CW'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         if (do_push_s && !do_pop_s) begin
            count_r <= count_r + CW'(1);
         end else if (!do_push_s && do_pop_s) begin
            count_r <= count_r - CW'(1);
         end else begin
            count_r <= count_r;
         end
      end
   end
endmodule

// File: rtl/interboard_tx_sched.sv
// -----------------------------------------------------------------------------
// interboard_tx_sched
// Queues messages from two requesters (game control, UI/status) with
// round-robin arbitration and launches them on the inter-board link one at a
// time while this board owns the link turn. After each launch it waits for
// the link to go busy (inter_ready low) and idle again (inter_ready high);
// if that does not complete within TIMEOUT wait cycles it pulses link_err and
// drops the message.
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   interboard_rst  reset requested by the remote board (same effect as rst)
//   bus             interboard_tx_sched_if.slave (requesters, link, status)
// -----------------------------------------------------------------------------
module interboard_tx_sched
   import interboard_tx_sched_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 interboard_rst,
   interboard_tx_sched_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   logic          rst_any_s;
   logic          grant_gc_s;
   logic          grant_ui_s;
   logic          can_accept_s;
   logic          push_s;
   logic          pop_s;
   msg_t          push_msg_s;
   msg_t          head_s;
   logic [MSG_WIDTH-1:0] fifo_rdata_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic [CW-1:0] fifo_count_s;

   tx_state_e     state_r;
   logic [15:0]   cnt_r;
   logic          last_gc_r;
   logic          ctrl_en_r;
   logic [4:0]    ctrl_number_r;
   logic [2:0]    ctrl_msg_type_r;
   logic          link_err_r;

   assign rst_any_s = rst || interboard_rst;

   // Round-robin grant: with both requesting, the one not served last wins.
   always_comb begin
      grant_gc_s = 1'b0;
      grant_ui_s = 1'b0;
      if (bus.gc_valid && bus.ui_valid) begin
         if (last_gc_r) begin
            grant_ui_s = 1'b1;
         end else begin
            grant_gc_s = 1'b1;
         end
      end else if (bus.gc_valid) begin
         grant_gc_s = 1'b1;
      end else if (bus.ui_valid) begin
         grant_ui_s = 1'b1;
      end else begin
         grant_gc_s = 1'b0;
         grant_ui_s = 1'b0;
      end
   end

   // The head is consumed exactly in the ISSUE cycle, which frees a slot for a same-cycle push.
   assign pop_s        = (state_r == ST_ISSUE) && !fifo_empty_s;
   assign can_accept_s = !fifo_full_s || pop_s;
   assign bus.gc_ready = !rst_any_s && can_accept_s && grant_gc_s;
   assign bus.ui_ready = !rst_any_s && can_accept_s && grant_ui_s;
   assign push_s       = (bus.gc_valid && bus.gc_ready) || (bus.ui_valid && bus.ui_ready);
   assign push_msg_s   = grant_gc_s ? pack_msg(bus.gc_msg_type, bus.gc_number)
                                    : pack_msg(bus.ui_msg_type, bus.ui_number);

   msg_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (MSG_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst_any_s),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (push_msg_s),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   assign head_s = msg_t'(fifo_rdata_s);

   // Last-granted pointer, moved only by an actual transfer.
   always_ff @(posedge clk) begin
      if (rst_any_s) begin
         last_gc_r <= 1'b0;
      end else if (bus.gc_valid && bus.gc_ready) begin
         last_gc_r <= 1'b1;
      end else if (bus.ui_valid && bus.ui_ready) begin
         last_gc_r <= 1'b0;
      end else begin
         last_gc_r <= last_gc_r;
      end
   end

   // Transmit FSM with registered ctrl_en/fields/link_err; the fields are loaded on
   // the IDLE->ISSUE edge so they are valid (and nonzero only) in the ctrl_en cycle.
   // cnt_r counts wait cycles; link_err is raised on the edge where it would reach TIMEOUT.
   always_ff @(posedge clk) begin
      if (rst_any_s) begin
         state_r         <= ST_IDLE;
         cnt_r           <= 16'd0;
         ctrl_en_r       <= 1'b0;
         ctrl_number_r   <= 5'd0;
         ctrl_msg_type_r <= 3'd0;
         link_err_r      <= 1'b0;
      end else begin
         ctrl_en_r       <= 1'b0;
         ctrl_number_r   <= 5'd0;
         ctrl_msg_type_r <= 3'd0;
         link_err_r      <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (!fifo_empty_s && bus.transmit && bus.inter_ready) begin
                  state_r         <= ST_ISSUE;
                  ctrl_en_r       <= 1'b1;
                  ctrl_number_r   <= head_s.number;
                  ctrl_msg_type_r <= head_s.msg_type;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               state_r <= ST_WAIT_LOW;
               cnt_r   <= 16'd0;
            end
            ST_WAIT_LOW: begin
               cnt_r <= cnt_r + 16'd1;
               if (!bus.inter_ready) begin
                  state_r <= ST_WAIT_HIGH;
               end else if (cnt_r + 16'd1 == TIMEOUT_C) begin
                  state_r    <= ST_IDLE;
                  link_err_r <= 1'b1;
               end else begin
                  state_r <= ST_WAIT_LOW;
               end
            end
            ST_WAIT_HIGH: begin
               cnt_r <= cnt_r + 16'd1;
               if (bus.inter_ready) begin
                  state_r <= ST_IDLE;
               end else if (cnt_r + 16'd1 == TIMEOUT_C) begin
                  state_r    <= ST_IDLE;
                  link_err_r <= 1'b1;
               end else begin
                  state_r <= ST_WAIT_HIGH;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ctrl_en       = ctrl_en_r;
   assign bus.ctrl_number   = ctrl_number_r;
   assign bus.ctrl_msg_type = ctrl_msg_type_r;
   assign bus.link_err      = link_err_r;
   assign bus.fifo_count    = fifo_count_s;
   assign bus.busy          = (state_r != ST_IDLE) || !fifo_empty_s;
endmodule

// File: tb/tb_interboard_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_interboard_tx_sched
// Directed bench for interboard_tx_sched (DEPTH=4, TIMEOUT=20). Inputs change
// 1 time unit after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_interboard_tx_sched;
   localparam int TB_DEPTH   = 4;
   localparam int TB_TIMEOUT = 20;

   logic clk = 1'b0;
   logic rst;
   logic interboard_rst;
   int   checks = 0;
   int   errors = 0;

   interboard_tx_sched_if #(.DEPTH(TB_DEPTH)) bus ();

   interboard_tx_sched #(
      .DEPTH   (TB_DEPTH),
      .TIMEOUT (TB_TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .interboard_rst (interboard_rst),
      .bus            (bus)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // Hard stop in case something wedges.
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for the next launch, check its fields, then complete the link handshake.
   task automatic drain_one(input logic [4:0] n, input logic [2:0] t);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         tick();
         if (bus.ctrl_en) seen = 1'b1;
      end
      chk("drain_seen", 32'(seen), 32'd1);
      chk("drain_number", 32'(bus.ctrl_number), 32'(n));
      chk("drain_type", 32'(bus.ctrl_msg_type), 32'(t));
      bus.inter_ready = 1'b0;
      tick();
      tick();
      bus.inter_ready = 1'b1;
      tick();
   endtask

   initial begin
      logic seen;
      int   waited;

      rst             = 1'b1;
      interboard_rst  = 1'b0;
      bus.transmit    = 1'b0;
      bus.inter_ready = 1'b0;
      bus.gc_valid    = 1'b1;
      bus.gc_number   = 5'd0;
      bus.gc_msg_type = 3'd0;
      bus.ui_valid    = 1'b1;
      bus.ui_number   = 5'd0;
      bus.ui_msg_type = 3'd0;
      tick();
      tick();

      // Reset state, readys held low while reset is active
      chk("rst_ctrl_en", 32'(bus.ctrl_en), 32'd0);
      chk("rst_link_err", 32'(bus.link_err), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_count", 32'(bus.fifo_count), 32'd0);
      chk("rst_number", 32'(bus.ctrl_number), 32'd0);
      chk("rst_type", 32'(bus.ctrl_msg_type), 32'd0);
      chk("rst_gc_ready", 32'(bus.gc_ready), 32'd0);
      chk("rst_ui_ready", 32'(bus.ui_ready), 32'd0);

      // Single gc message: ctrl_en two cycles after the push
      rst             = 1'b0;
      bus.ui_valid    = 1'b0;
      bus.transmit    = 1'b1;
      bus.inter_ready = 1'b1;
      bus.gc_number   = 5'd17;
      bus.gc_msg_type = 3'd3;
      #1;
      chk("lat_gc_ready", 32'(bus.gc_ready), 32'd1);
      chk("lat_ui_ready", 32'(bus.ui_ready), 32'd0);
      tick();
      bus.gc_valid = 1'b0;
      chk("lat_cyc1_en", 32'(bus.ctrl_en), 32'd0);
      chk("lat_cyc1_count", 32'(bus.fifo_count), 32'd1);
      tick();
      chk("lat_cyc2_en", 32'(bus.ctrl_en), 32'd1);
      chk("lat_number", 32'(bus.ctrl_number), 32'd17);
      chk("lat_type", 32'(bus.ctrl_msg_type), 32'd3);
      tick();
      chk("post_en", 32'(bus.ctrl_en), 32'd0);
      chk("post_number_zero", 32'(bus.ctrl_number), 32'd0);
      chk("post_type_zero", 32'(bus.ctrl_msg_type), 32'd0);
      chk("post_count", 32'(bus.fifo_count), 32'd0);
      chk("post_busy", 32'(bus.busy), 32'd1);
      bus.inter_ready = 1'b0;
      tick();
      bus.inter_ready = 1'b1;
      tick();
      chk("handshake_idle", 32'(bus.busy), 32'd0);
      chk("handshake_no_err", 32'(bus.link_err), 32'd0);

      // Round-robin fill with transmit low: gc,ui,gc,ui
      rst = 1'b1;
      tick();
      rst             = 1'b0;
      bus.transmit    = 1'b0;
      bus.gc_valid    = 1'b1;
      bus.ui_valid    = 1'b1;
      bus.gc_msg_type = 3'd1;
      bus.ui_msg_type = 3'd2;
      for (int i = 0; i < 4; i++) begin
         bus.gc_number = 5'(10 + i);
         bus.ui_number = 5'(10 + i);
         #1;
         chk("rr_gc_ready", 32'(bus.gc_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_ui_ready", 32'(bus.ui_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
         tick();
      end
      chk("rr_count", 32'(bus.fifo_count), 32'd4);
      chk("full_gc_ready", 32'(bus.gc_ready), 32'd0);
      chk("full_ui_ready", 32'(bus.ui_ready), 32'd0);

      // Full FIFO: ui push accepted only in the ISSUE cycle, count stays 4
      bus.gc_valid    = 1'b0;
      bus.ui_number   = 5'd22;
      bus.ui_msg_type = 3'd4;
      bus.transmit    = 1'b1;
      bus.inter_ready = 1'b1;
      #1;
      chk("full_idle_ui_ready", 32'(bus.ui_ready), 32'd0);
      tick();
      chk("full_issue_en", 32'(bus.ctrl_en), 32'd1);
      chk("full_issue_number", 32'(bus.ctrl_number), 32'd10);
      chk("full_issue_type", 32'(bus.ctrl_msg_type), 32'd1);
      chk("full_issue_ui_ready", 32'(bus.ui_ready), 32'd1);
      tick();
      bus.ui_valid = 1'b0;
      chk("full_pushpop_count", 32'(bus.fifo_count), 32'd4);
      bus.inter_ready = 1'b0;
      tick();
      bus.inter_ready = 1'b1;
      tick();
      drain_one(5'd11, 3'd2);
      drain_one(5'd12, 3'd1);
      drain_one(5'd13, 3'd2);
      drain_one(5'd22, 3'd4);
      chk("drained_count", 32'(bus.fifo_count), 32'd0);
      chk("drained_busy", 32'(bus.busy), 32'd0);

      // transmit low holds off launches; rise launches next cycle
      bus.transmit    = 1'b0;
      bus.gc_valid    = 1'b1;
      bus.gc_number   = 5'd7;
      bus.gc_msg_type = 3'd5;
      tick();
      bus.gc_number   = 5'd8;
      bus.gc_msg_type = 3'd6;
      tick();
      bus.gc_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("hold_no_en", 32'(bus.ctrl_en), 32'd0);
         tick();
      end
      chk("hold_count", 32'(bus.fifo_count), 32'd2);
      bus.transmit = 1'b1;
      tick();
      chk("rise_en", 32'(bus.ctrl_en), 32'd1);
      chk("rise_number", 32'(bus.ctrl_number), 32'd7);
      chk("rise_type", 32'(bus.ctrl_msg_type), 32'd5);

      // inter_ready never drops: link_err after TIMEOUT wait cycles
      seen   = 1'b0;
      waited = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
         tick();
         waited++;
         if (bus.link_err) seen = 1'b1;
      end
      bus.transmit = 1'b0;
      chk("timeout_seen", 32'(seen), 32'd1);
      chk("timeout_cycles", 32'(waited), 32'(TB_TIMEOUT + 1));
      chk("timeout_count", 32'(bus.fifo_count), 32'd1);
      tick();
      chk("timeout_pulse_end", 32'(bus.link_err), 32'd0);
      chk("timeout_busy_queued", 32'(bus.busy), 32'd1);

      // interboard_rst in WAIT_HIGH with 3 queued aborts everything
      bus.gc_valid    = 1'b1;
      bus.gc_msg_type = 3'd7;
      for (int i = 0; i < 3; i++) begin
         bus.gc_number = 5'(20 + i);
         tick();
      end
      bus.gc_valid = 1'b0;
      chk("abort_fill_count", 32'(bus.fifo_count), 32'd4);
      bus.transmit = 1'b1;
      tick();
      chk("abort_issue_en", 32'(bus.ctrl_en), 32'd1);
      chk("abort_issue_number", 32'(bus.ctrl_number), 32'd8);
      bus.transmit    = 1'b0;
      bus.inter_ready = 1'b0;
      tick();
      tick();
      chk("abort_wait_count", 32'(bus.fifo_count), 32'd3);
      chk("abort_wait_busy", 32'(bus.busy), 32'd1);
      interboard_rst = 1'b1;
      bus.gc_valid   = 1'b1;
      #1;
      chk("abort_gc_ready", 32'(bus.gc_ready), 32'd0);
      tick();
      chk("abort_count", 32'(bus.fifo_count), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_no_en", 32'(bus.ctrl_en), 32'd0);
      chk("abort_no_err", 32'(bus.link_err), 32'd0);
      interboard_rst  = 1'b0;
      bus.gc_valid    = 1'b0;
      bus.inter_ready = 1'b1;
      bus.transmit    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("after_abort_no_en", 32'(bus.ctrl_en), 32'd0);
         chk("after_abort_no_err", 32'(bus.link_err), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/interboard_tx_sched.md
INTERBOARD_TX_SCHED -- requirements
Module: interboard_tx_sched

Interface
REQ-001 Parameter DEPTH, default 4, sets the message FIFO depth in entries; it SHALL be a power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 1000, sets the number of cycles the block SHALL wait for link completion before flagging an error.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 interboard_rst  in  1  reset requested by the remote board; same effect as rst.
REQ-006 transmit  in  1  high while this board owns the link turn.
REQ-007 inter_ready  in  1  sender idle indication from the link.
REQ-008 gc_valid, gc_number[4:0], gc_msg_type[2:0]  in  1/5/3  game-control requester.
REQ-009 ui_valid, ui_number[4:0], ui_msg_type[2:0]  in  1/5/3  UI/status requester.
REQ-010 gc_ready, ui_ready  out  1  acceptance strobes; a message transfers on valid&&ready.
REQ-011 ctrl_en  out  1  one-cycle pulse launching a message on the link.
REQ-012 ctrl_number[4:0], ctrl_msg_type[2:0]  out  5/3  message fields, valid in the ctrl_en cycle.
REQ-013 busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
REQ-014 fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 link_err  out  1  one-cycle pulse on timeout.

Function
REQ-016 Accept: at most one requester SHALL be granted per cycle, and only when the FIFO is not full or a pop occurs in the same cycle.
REQ-017 Arbitration: with both valid, the grant SHALL alternate round-robin, and the last-granted pointer SHALL update only on a transfer; after reset gc SHALL have priority.
REQ-018 The ready outputs SHALL be combinational from the grant and the full/pop state, and SHALL never both be high.
REQ-019 The FIFO SHALL store {msg_type, number} (8 bits), FIFO order, with wrap-around pointers.
REQ-020 Simultaneous push and pop when full SHALL succeed with no change in count; pop when empty SHALL be impossible.
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
REQ-022 IDLE->ISSUE SHALL occur when the FIFO is non-empty, transmit=1 and inter_ready=1.
REQ-023 In ISSUE the block SHALL raise ctrl_en for exactly one cycle with the head entry on ctrl_number/ctrl_msg_type, pop the FIFO in that cycle, and go to WAIT_LOW.
REQ-024 WAIT_LOW->WAIT_HIGH SHALL occur when inter_ready=0.
REQ-025 WAIT_HIGH->IDLE SHALL occur when inter_ready=1.
REQ-026 Latency SHALL be 2 cycles from push into an empty FIFO in IDLE to ctrl_en.
REQ-027 A 16-bit cycle counter SHALL clear on entry to WAIT_LOW and increment in WAIT_LOW/WAIT_HIGH.
REQ-028 When the counter reaches TIMEOUT, the block SHALL pulse link_err and go to IDLE; the popped message SHALL be discarded.
REQ-029 If transmit falls in WAIT_LOW/WAIT_HIGH, the FSM SHALL continue; new issues SHALL wait for transmit=1.
REQ-030 ctrl_number/ctrl_msg_type SHALL be 0 outside the ctrl_en cycle.

Reset
REQ-031 rst or interboard_rst SHALL flush the FIFO (count 0), force IDLE, clear the counter, and reset the arbiter pointer to gc.
REQ-032 Reset values: ctrl_en=0, link_err=0, busy=0, fifo_count=0, ctrl fields 0; gc_ready and ui_ready SHALL be 0 while reset is asserted.
REQ-033 A reset mid-message SHALL abort the message without a ctrl_en or link_err pulse.

Structure
REQ-034 The msg_type encodings, the FSM state encoding and the TIMEOUT default SHALL live in the shared interboard package.
REQ-035 The FIFO SHALL be a sub-module msg_fifo (parameters DEPTH, WIDTH=8; push/pop/full/empty/count).

Verification
REQ-036 gc pushes {type=3, num=17}, transmit=1, inter_ready=1 -> ctrl_en 2 cycles later with ctrl_number=17, ctrl_msg_type=3.
REQ-037 gc and ui both valid for 4 cycles, FIFO empty, transmit=0 -> grants gc,ui,gc,ui; fifo_count=4; both readys 0.
REQ-038 Full FIFO, ISSUE-cycle pop with simultaneous ui push -> count stays 4, order preserved.
REQ-039 After ctrl_en, inter_ready held 1 -> link_err pulse at TIMEOUT cycles, return to IDLE, fifo_count decremented by 1.
REQ-040 interboard_rst during WAIT_HIGH with 3 queued -> next cycle fifo_count=0, IDLE, no ctrl_en pulse.
REQ-041 transmit=0 with a queued message -> no ctrl_en; transmit rises -> ctrl_en next cycle.
